// File: rtl/impact_seq_pkg.sv
// Shared definitions for the IMPACT op sequencer: op encodings, FSM states, phase-timer width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package impact_seq_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;

    // Width of the per-phase down-counter; phase lengths are 1..15 cycles.
    localparam int PHASE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PRECH = 3'd2,
        ST_WL    = 3'd3,
        ST_SENSE = 3'd4,
        ST_CAPT  = 3'd5,
        ST_RESP  = 3'd6
    } seq_state_t;

    // Even-parity bit per byte lane: the bit that makes each lane's ones-count even.
    function automatic logic [3:0] byte_parity(input logic [31:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/impact_phase_timer.sv
// Loadable down-counter timing one macro phase; done is high while the count is 0.
// Latency: load takes effect on the next clock edge; counts down one per cycle after that.
// Backpressure: none; the sequencer reloads it on every phase entry.
module impact_phase_timer
    import impact_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PHASE_W-1:0] load_val,
    output logic               done
);

    logic [PHASE_W-1:0] cnt;

    // Load N-1 on phase entry, then count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/impact_op_sequencer.sv
// Turns word/byte read-write commands into timed IMPACT macro control sequences (load, precharge, WL, sense).
// Latency at defaults: word write 21, byte write 6, word read 25, byte read 7, reserved op 2 cycles to rsp_valid.
// Backpressure: cmd_ready only in IDLE; rsp_valid/rsp_data held until rsp_ready, no new command before that.
// Optional: define IMPACT_SEQ_PARITY_EN to add rsp_parity[3:0] (even parity per rsp_data byte).
module impact_op_sequencer
    import impact_seq_pkg::*;
#(
    parameter int PRECHARGE_CYC = 2,
    parameter int WL_CYC        = 2,
    parameter int SENSE_CYC     = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_proj,
    input  logic        cmd_byte_mode,
    input  logic [1:0]  cmd_byte_sel,
    input  logic        cmd_trunc,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
`ifdef IMPACT_SEQ_PARITY_EN
    output logic [3:0]  rsp_parity,
`endif
    output logic        busy,
    output logic [7:0]  Data_In,
    output logic [1:0]  Byte_Select,
    output logic [1:0]  Proj_Select,
    output logic        Data_In_Enable,
    output logic        WriteEnable,
    output logic        ReadEnable,
    output logic        WL_enable,
    output logic        Byte_Mode_Enable,
    output logic        Trunc_Enable,
    output logic        PreCharge,
    input  logic [7:0]  Data_Out
);

    if (PRECHARGE_CYC < 1 || PRECHARGE_CYC > 15 ||
        WL_CYC        < 1 || WL_CYC        > 15 ||
        SENSE_CYC     < 1 || SENSE_CYC     > 15) begin : g_bad_param
        $error("impact_op_sequencer: phase cycle counts must be in 1..15");
    end

    localparam logic [PHASE_W-1:0] PRECH_LD = PHASE_W'(PRECHARGE_CYC - 1);
    localparam logic [PHASE_W-1:0] WL_LD    = PHASE_W'(WL_CYC - 1);
    localparam logic [PHASE_W-1:0] SENSE_LD = PHASE_W'(SENSE_CYC - 1);

    seq_state_t         state, state_d;
    logic [1:0]         idx, idx_d;
    logic [1:0]         op_q, op_d;
    logic [31:0]        data_q, data_src;
    logic [31:0]        rsp_data_d;
    logic               rsp_err_d;
    logic               byte_mode_q;
    logic               accept;
    logic               last_byte;
    logic               in_iter_d;
    logic               tmr_load;
    logic [PHASE_W-1:0] tmr_val;
    logic               tmr_done;

    assign accept    = cmd_valid && cmd_ready;
    // Outputs are registered from next-state values, so at the accept edge
    // the live command fields stand in for the not-yet-captured copies.
    assign op_d      = accept ? cmd_op   : op_q;
    assign data_src  = accept ? cmd_data : data_q;
    assign last_byte = byte_mode_q || (idx == 2'd3);
    assign in_iter_d = !op_d[1] &&
                       (state_d inside {ST_LOAD, ST_PRECH, ST_WL, ST_SENSE, ST_CAPT});

    impact_phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Next-state, byte index, phase-timer loads and response accumulation.
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        rsp_data_d = rsp_data;
        rsp_err_d  = rsp_err;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    idx_d      = cmd_byte_mode ? cmd_byte_sel : 2'd0;
                    rsp_data_d = '0;
                    rsp_err_d  = cmd_op[1];
                    if (cmd_op == OP_WRITE) begin
                        state_d = ST_LOAD;
                    end else if (cmd_op == OP_READ) begin
                        state_d  = ST_PRECH;
                        tmr_load = 1'b1;
                        tmr_val  = PRECH_LD;
                    end else begin
                        // Reserved op: one quiet cycle, then report the error.
                        state_d = ST_CAPT;
                    end
                end
            end
            ST_LOAD: begin
                state_d  = ST_PRECH;
                tmr_load = 1'b1;
                tmr_val  = PRECH_LD;
            end
            ST_PRECH: begin
                if (tmr_done) begin
                    state_d  = ST_WL;
                    tmr_load = 1'b1;
                    tmr_val  = WL_LD;
                end
            end
            ST_WL: begin
                if (tmr_done) begin
                    if (op_q == OP_READ) begin
                        state_d  = ST_SENSE;
                        tmr_load = 1'b1;
                        tmr_val  = SENSE_LD;
                    end else if (last_byte) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_LOAD;
                        idx_d   = idx + 2'd1;
                    end
                end
            end
            ST_SENSE: begin
                if (tmr_done) begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                if (op_q == OP_READ) begin
                    rsp_data_d[{idx, 3'b000} +: 8] = Data_Out;
                    if (!last_byte) begin
                        state_d  = ST_PRECH;
                        idx_d    = idx + 2'd1;
                        tmr_load = 1'b1;
                        tmr_val  = PRECH_LD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d    = ST_IDLE;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, byte index and the command fields captured at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            op_q        <= OP_WRITE;
            data_q      <= '0;
            byte_mode_q <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            if (accept) begin
                op_q        <= cmd_op;
                data_q      <= cmd_data;
                byte_mode_q <= cmd_byte_mode;
            end
        end
    end

    // Registered handshake, response and macro-pin outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready        <= 1'b1;
            busy             <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_data         <= '0;
            rsp_err          <= 1'b0;
            Data_In          <= '0;
            Data_In_Enable   <= 1'b0;
            Byte_Select      <= '0;
            PreCharge        <= 1'b0;
            WL_enable        <= 1'b0;
            WriteEnable      <= 1'b0;
            ReadEnable       <= 1'b0;
            Proj_Select      <= '0;
            Byte_Mode_Enable <= 1'b0;
            Trunc_Enable     <= 1'b0;
        end else begin
            cmd_ready      <= (state_d == ST_IDLE);
            busy           <= (state_d != ST_IDLE);
            rsp_valid      <= (state_d == ST_RESP);
            rsp_data       <= rsp_data_d;
            rsp_err        <= rsp_err_d;
            Data_In_Enable <= (state_d == ST_LOAD);
            Data_In        <= (state_d == ST_LOAD) ? data_src[{idx_d, 3'b000} +: 8] : 8'd0;
            Byte_Select    <= in_iter_d ? idx_d : 2'd0;
            PreCharge      <= (state_d == ST_PRECH);
            WL_enable      <= (state_d == ST_WL);
            WriteEnable    <= (state_d == ST_WL) && (op_d == OP_WRITE);
            ReadEnable     <= ((state_d == ST_WL) || (state_d == ST_SENSE)) && (op_d == OP_READ);
            // Operation-wide macro modes: set at acceptance of a real op, dropped back in IDLE.
            if (accept && !cmd_op[1]) begin
                Proj_Select      <= cmd_proj;
                Byte_Mode_Enable <= cmd_byte_mode;
                Trunc_Enable     <= cmd_trunc;
            end else if (state_d == ST_IDLE) begin
                Proj_Select      <= '0;
                Byte_Mode_Enable <= 1'b0;
                Trunc_Enable     <= 1'b0;
            end
        end
    end

`ifdef IMPACT_SEQ_PARITY_EN
    // Per-lane parity tracks rsp_data exactly, so it is valid alongside rsp_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_parity <= '0;
        end else begin
            rsp_parity <= byte_parity(rsp_data_d);
        end
    end
`endif

endmodule

// File: tb/tb_impact_op_sequencer.sv
// Directed self-checking bench for impact_op_sequencer at default phase lengths.
// Latency figures count the acceptance edge as cycle 1.
// Backpressure is exercised by stalling rsp_ready with a command pending.
module tb_impact_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op, cmd_proj, cmd_byte_sel;
    logic        cmd_byte_mode, cmd_trunc;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_data;
`ifdef IMPACT_SEQ_PARITY_EN
    logic [3:0]  rsp_parity;
`endif
    logic [7:0]  Data_In, Data_Out;
    logic [1:0]  Byte_Select, Proj_Select;
    logic        Data_In_Enable, WriteEnable, ReadEnable, WL_enable;
    logic        Byte_Mode_Enable, Trunc_Enable, PreCharge;

    // Macro read model: either 0x10 + lane, or a fixed byte.
    logic        dout_inc;
    logic [7:0]  dout_const;
    assign Data_Out = dout_inc ? (8'h10 + {6'd0, Byte_Select}) : dout_const;

    int n_chk  = 0;
    int n_pass = 0;

    int n_die, n_pre, n_wl, n_we, n_re, n_viol, n_act;
    logic [7:0] di_log[$];
    logic [1:0] bs_log[$];

    always #5 clk = ~clk;

    impact_op_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_proj         (cmd_proj),
        .cmd_byte_mode    (cmd_byte_mode),
        .cmd_byte_sel     (cmd_byte_sel),
        .cmd_trunc        (cmd_trunc),
        .cmd_data         (cmd_data),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
`ifdef IMPACT_SEQ_PARITY_EN
        .rsp_parity       (rsp_parity),
`endif
        .busy             (busy),
        .Data_In          (Data_In),
        .Byte_Select      (Byte_Select),
        .Proj_Select      (Proj_Select),
        .Data_In_Enable   (Data_In_Enable),
        .WriteEnable      (WriteEnable),
        .ReadEnable       (ReadEnable),
        .WL_enable        (WL_enable),
        .Byte_Mode_Enable (Byte_Mode_Enable),
        .Trunc_Enable     (Trunc_Enable),
        .PreCharge        (PreCharge),
        .Data_Out         (Data_Out)
    );

    // Per-cycle tally of macro pin activity, sampled mid-cycle.
    always @(negedge clk) begin
        if (Data_In_Enable) begin
            n_die++;
            di_log.push_back(Data_In);
        end
        if (PreCharge)   n_pre++;
        if (WL_enable)   n_wl++;
        if (WriteEnable) n_we++;
        if (ReadEnable)  n_re++;
        if (Data_In_Enable || PreCharge || WL_enable || ReadEnable || WriteEnable)
            bs_log.push_back(Byte_Select);
        if ((int'(Data_In_Enable) + int'(PreCharge) + int'(WL_enable)) > 1 ||
            (!Data_In_Enable && Data_In != 8'd0))
            n_viol++;
        if (Data_In_Enable || PreCharge || WL_enable || ReadEnable || WriteEnable ||
            Byte_Mode_Enable || Trunc_Enable || Proj_Select != 2'd0 ||
            Byte_Select != 2'd0 || Data_In != 8'd0)
            n_act++;
    end

    task automatic clear_mon();
        n_die = 0; n_pre = 0; n_wl = 0; n_we = 0; n_re = 0; n_viol = 0; n_act = 0;
        di_log.delete();
        bs_log.delete();
    endtask

    // Offer one command, return cycles from acceptance edge (cycle 1) to rsp_valid.
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] proj, input logic bm,
                           input logic [1:0] bs, input logic tr, input logic [31:0] d,
                           output int lat);
        @(negedge clk);
        clear_mon();
        cmd_op = op; cmd_proj = proj; cmd_byte_mode = bm; cmd_byte_sel = bs;
        cmd_trunc = tr; cmd_data = d; cmd_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); else n_pass++;
        n_chk++; if ({rsp_valid, rsp_err, busy} !== 3'b000) $display("FAIL reset_rsp_busy got %b exp 000", {rsp_valid, rsp_err, busy}); else n_pass++;
        n_chk++; if (rsp_data !== 32'd0) $display("FAIL reset_rsp_data got %h exp 0", rsp_data); else n_pass++;
        n_chk++; if ({Data_In, Byte_Select, Proj_Select, Data_In_Enable, WriteEnable, ReadEnable,
                      WL_enable, Byte_Mode_Enable, Trunc_Enable, PreCharge} !== 19'd0)
            $display("FAIL reset_controls got %h exp 0", {Data_In, Byte_Select, Proj_Select, Data_In_Enable,
                     WriteEnable, ReadEnable, WL_enable, Byte_Mode_Enable, Trunc_Enable, PreCharge});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word_write();
        int lat;
        int bad;
        run_cmd(2'b00, 2'b10, 1'b0, 2'd0, 1'b1, 32'hA1B2C3D4, lat);
        n_chk++; if (lat !== 21) $display("FAIL wr_latency got %0d exp 21", lat); else n_pass++;
        n_chk++; if (rsp_data !== 32'd0 || rsp_err !== 1'b0) $display("FAIL wr_rsp got %h/%b exp 0/0", rsp_data, rsp_err); else n_pass++;
        n_chk++; if ({n_die, n_pre, n_wl, n_we, n_re} !== {32'd4, 32'd8, 32'd8, 32'd8, 32'd0})
            $display("FAIL wr_pulses got die=%0d pre=%0d wl=%0d we=%0d re=%0d exp 4 8 8 8 0", n_die, n_pre, n_wl, n_we, n_re);
        else n_pass++;
        n_chk++; if (di_log.size() !== 4 || {di_log[3], di_log[2], di_log[1], di_log[0]} !== 32'hA1B2C3D4)
            $display("FAIL wr_data_in got %0d bytes exp D4 C3 B2 A1", di_log.size());
        else n_pass++;
        bad = 0;
        foreach (bs_log[i]) if (bs_log[i] !== 2'(i / 5)) bad++;
        n_chk++; if (bs_log.size() !== 20 || bad !== 0) $display("FAIL wr_byte_select got size=%0d bad=%0d exp 20/0", bs_log.size(), bad); else n_pass++;
        n_chk++; if (n_viol !== 0) $display("FAIL wr_exclusive got %0d exp 0", n_viol); else n_pass++;
        n_chk++; if ({Proj_Select, Trunc_Enable, Byte_Mode_Enable} !== 4'b1010)
            $display("FAIL wr_modes_held got %b exp 1010", {Proj_Select, Trunc_Enable, Byte_Mode_Enable});
        else n_pass++;
        consume();
        n_chk++; if ({Proj_Select, Trunc_Enable, rsp_valid, cmd_ready} !== 5'b00001)
            $display("FAIL wr_idle_after got %b exp 00001", {Proj_Select, Trunc_Enable, rsp_valid, cmd_ready});
        else n_pass++;
    endtask

    task automatic test_word_read();
        int lat;
        int bad;
        dout_inc = 1'b1;
        run_cmd(2'b01, 2'b01, 1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF, lat);
        n_chk++; if (lat !== 25) $display("FAIL rd_latency got %0d exp 25", lat); else n_pass++;
        n_chk++; if (rsp_data !== 32'h13121110) $display("FAIL rd_data got %h exp 13121110", rsp_data); else n_pass++;
        n_chk++; if ({n_die, n_pre, n_wl, n_we, n_re} !== {32'd0, 32'd8, 32'd8, 32'd0, 32'd12})
            $display("FAIL rd_pulses got die=%0d pre=%0d wl=%0d we=%0d re=%0d exp 0 8 8 0 12", n_die, n_pre, n_wl, n_we, n_re);
        else n_pass++;
        bad = 0;
        foreach (bs_log[i]) if (bs_log[i] !== 2'(i / 5)) bad++;
        n_chk++; if (bs_log.size() !== 20 || bad !== 0) $display("FAIL rd_byte_select got size=%0d bad=%0d exp 20/0", bs_log.size(), bad); else n_pass++;
`ifdef IMPACT_SEQ_PARITY_EN
        n_chk++; if (rsp_parity !== 4'b1001) $display("FAIL rd_parity got %b exp 1001", rsp_parity); else n_pass++;
`endif
        consume();
        dout_inc = 1'b0;
    endtask

    task automatic test_byte_read();
        int lat;
        int bad;
        dout_const = 8'h5A;
        run_cmd(2'b01, 2'b00, 1'b1, 2'd2, 1'b0, 32'd0, lat);
        n_chk++; if (lat !== 7) $display("FAIL brd_latency got %0d exp 7", lat); else n_pass++;
        n_chk++; if (rsp_data !== 32'h005A0000) $display("FAIL brd_data got %h exp 005A0000", rsp_data); else n_pass++;
        bad = 0;
        foreach (bs_log[i]) if (bs_log[i] !== 2'd2) bad++;
        n_chk++; if (bs_log.size() !== 5 || bad !== 0) $display("FAIL brd_byte_select got size=%0d bad=%0d exp 5/0", bs_log.size(), bad); else n_pass++;
        n_chk++; if (Byte_Mode_Enable !== 1'b1) $display("FAIL brd_byte_mode got %b exp 1", Byte_Mode_Enable); else n_pass++;
        consume();
    endtask

    task automatic test_back_pressure();
        int lat;
        int bad;
        dout_const = 8'hC7;
        run_cmd(2'b01, 2'b00, 1'b1, 2'd3, 1'b0, 32'd0, lat);
        n_chk++; if (rsp_data !== 32'hC7000000) $display("FAIL bp_first_data got %h exp C7000000", rsp_data); else n_pass++;
        // Offer a byte write while the response is stalled.
        cmd_op = 2'b00; cmd_byte_mode = 1'b1; cmd_byte_sel = 2'd0; cmd_data = 32'h77;
        cmd_valid = 1'b1;
        rsp_ready = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if ({rsp_valid, cmd_ready, rsp_data} !== {1'b1, 1'b0, 32'hC7000000}) bad++;
        end
        n_chk++; if (bad !== 0) $display("FAIL bp_stall_stable got %0d bad cycles exp 0", bad); else n_pass++;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        n_chk++; if ({cmd_ready, rsp_valid} !== 2'b10) $display("FAIL bp_release got %b exp 10", {cmd_ready, rsp_valid}); else n_pass++;
        clear_mon();
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_chk++; if (lat !== 6) $display("FAIL bp_next_latency got %0d exp 6", lat); else n_pass++;
        n_chk++; if (di_log.size() !== 1 || di_log[0] !== 8'h77) $display("FAIL bp_next_data_in got %0d bytes exp one 77", di_log.size()); else n_pass++;
        consume();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int wait_cyc;
        @(negedge clk);
        cmd_op = 2'b00; cmd_proj = 2'b11; cmd_byte_mode = 1'b0; cmd_byte_sel = 2'd0;
        cmd_trunc = 1'b1; cmd_data = 32'h01020304; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_cyc = 0;
        while (!(WL_enable && Byte_Select == 2'd1) && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_chk++; if (wait_cyc >= 50) $display("FAIL rstmid_reach_wl got timeout exp WL on byte 1"); else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++; if ({Data_In, Byte_Select, Proj_Select, Data_In_Enable, WriteEnable, ReadEnable,
                      WL_enable, Byte_Mode_Enable, Trunc_Enable, PreCharge} !== 19'd0)
            $display("FAIL rstmid_controls got %h exp 0", {Data_In, Byte_Select, Proj_Select, Data_In_Enable,
                     WriteEnable, ReadEnable, WL_enable, Byte_Mode_Enable, Trunc_Enable, PreCharge});
        else n_pass++;
        n_chk++; if ({cmd_ready, busy} !== 2'b10) $display("FAIL rstmid_ready got %b exp 10", {cmd_ready, busy}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        dout_inc = 1'b1;
        run_cmd(2'b01, 2'b00, 1'b0, 2'd0, 1'b0, 32'd0, lat);
        n_chk++; if (lat !== 25 || rsp_data !== 32'h13121110)
            $display("FAIL rstmid_read_after got lat=%0d data=%h exp 25/13121110", lat, rsp_data);
        else n_pass++;
        consume();
        dout_inc = 1'b0;
    endtask

    task automatic test_reserved_op();
        int lat;
        run_cmd(2'b11, 2'b00, 1'b0, 2'd0, 1'b0, 32'hDEADBEEF, lat);
        n_chk++; if (lat !== 2) $display("FAIL rsv_latency got %0d exp 2", lat); else n_pass++;
        n_chk++; if ({rsp_err, rsp_data} !== {1'b1, 32'd0}) $display("FAIL rsv_rsp got err=%b data=%h exp 1/0", rsp_err, rsp_data); else n_pass++;
        n_chk++; if (n_act !== 0) $display("FAIL rsv_no_activity got %0d active cycles exp 0", n_act); else n_pass++;
        consume();
        n_chk++; if ({rsp_err, cmd_ready} !== 2'b01) $display("FAIL rsv_cleared got %b exp 01", {rsp_err, cmd_ready}); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_proj = 2'b00; cmd_byte_mode = 1'b0;
        cmd_byte_sel = 2'd0; cmd_trunc = 1'b0; cmd_data = 32'd0; rsp_ready = 1'b0;
        dout_inc = 1'b0; dout_const = 8'h00;
        clear_mon();
        test_reset();
        test_word_write();
        test_word_read();
        test_byte_read();
        test_back_pressure();
        test_reset_mid_op();
        test_reserved_op();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/impact_op_sequencer.md
Name: impact_op_sequencer

Overview:
- Upstream stage for the IMPACT in-memory-compute macro head.
- Accepts 32-bit word or single-byte read/write commands over a valid/ready interface.
- Generates the timed macro control sequence: data load, precharge, word-line and sense.
- For reads, collects Data_Out bytes into a 32-bit response. It replaces direct pad-level pin wiggling by the host.

Parameters:
- PRECHARGE_CYC, 2: cycles PreCharge is held high per byte access (range 1..15).
- WL_CYC, 2: cycles WL_enable plus WriteEnable or ReadEnable are held per byte access (range 1..15).
- SENSE_CYC, 1: extra read cycles with ReadEnable held, WL_enable low, before Data_Out capture (range 1..15).
- Out-of-range values fail elaboration.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 write, 01 read, 1x reserved.
- cmd_proj  in  2  project select, drives Proj_Select.
- cmd_byte_mode  in  1  1 = single-byte access.
- cmd_byte_sel  in  2  byte lane used when cmd_byte_mode = 1.
- cmd_trunc  in  1  drives Trunc_Enable for the whole operation.
- cmd_data  in  32  write data; byte n is bits [8n+7:8n].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  read data; 0 for writes and reserved ops.
- rsp_err  out  1  reserved op was issued.
- busy  out  1  high whenever not IDLE.
- Data_In  out  8  macro data in.
- Byte_Select  out  2  macro byte lane.
- Proj_Select  out  2  macro project select.
- Data_In_Enable  out  1  macro data-in strobe.
- WriteEnable  out  1  macro write enable.
- ReadEnable  out  1  macro read enable.
- WL_enable  out  1  macro word-line enable.
- Byte_Mode_Enable  out  1  macro byte-mode enable.
- Trunc_Enable  out  1  macro truncation enable.
- PreCharge  out  1  macro precharge.
- Data_Out  in  8  macro read data.

Behaviour:
- Reset: all outputs are registered. Everything is 0 except cmd_ready = 1. The FSM goes to IDLE.
- Reset mid-operation: the current command is dropped and all macro controls deassert immediately (asynchronously).
- Handshake:
  - A command is accepted on cmd_valid & cmd_ready.
  - All command fields are registered at acceptance; Proj_Select, Byte_Mode_Enable and Trunc_Enable are held from acceptance until return to IDLE.
  - rsp_valid stays high with stable data until rsp_ready. No new command is accepted before the response is consumed.
- FSM states: IDLE, LOAD, PRECH, WL, SENSE, CAPT, RESP.
- Byte index:
  - Word mode iterates idx 0,1,2,3.
  - Byte mode runs one iteration with idx = cmd_byte_sel.
  - Byte_Select = idx throughout each iteration.
- Write iteration:
  - LOAD, 1 cycle: Data_In = data byte idx, Data_In_Enable = 1.
  - PRECH, PRECHARGE_CYC cycles: PreCharge = 1.
  - WL, WL_CYC cycles: WL_enable = WriteEnable = 1.
  - Then the next idx, or RESP after the last byte.
- Read iteration:
  - PRECH, then WL (WL_enable = ReadEnable = 1).
  - SENSE, SENSE_CYC cycles: ReadEnable = 1.
  - CAPT, 1 cycle: Data_Out is registered into rsp_data lane idx. Other lanes are unchanged; they were zeroed at acceptance.
- Control exclusivity: PreCharge, WL_enable and Data_In_Enable are never high together. Data_In is 0 outside LOAD.
- Latency, accept to rsp_valid, at defaults:
  - Write: per byte 1 + P + W = 5 cycles; word 20, byte 5, plus 1 cycle to enter RESP.
  - Read: per byte P + W + S + 1 = 6 cycles; word 24, byte 6, plus 1.
- Reserved op: accepted with no macro activity. Next cycle RESP with rsp_err = 1 and rsp_data = 0.
- Phase counter: 4 bits, loaded with N-1 on phase entry. The phase exits when the counter reaches 0.

Optional Feature:
- Macro: IMPACT_SEQ_PARITY_EN.
- Defined: adds output rsp_parity[3:0], the even parity of each rsp_data byte, valid with rsp_valid and 0 for writes.
- Undefined: the port and its logic are absent.

Decomposition:
- Package impact_seq_pkg holds:
  - the op encoding constants: OP_WRITE = 2'b00, OP_READ = 2'b01;
  - the FSM state enum;
  - the phase-counter width constant (4).
- Sub-module impact_phase_timer: loadable down-counter with a done flag, reused for the PRECH, WL and SENSE phases.

Test Plan:
- Word write, cmd_data = 32'hA1B2C3D4, proj = 2'b10:
  - Data_In sequence D4, C3, B2, A1 with Byte_Select 0..3.
  - Each byte: 1 Data_In_Enable, 2 PreCharge, 2 WL_enable + WriteEnable cycles.
  - rsp_valid at cycle 21, rsp_data = 0.
- Word read with Data_Out model returning 8'h10 + idx:
  - rsp_data = 32'h13121110, rsp_valid at cycle 25.
  - ReadEnable high for 3 cycles per byte.
- Byte-mode read with byte_sel = 2 and Data_Out = 8'h5A:
  - Single iteration with Byte_Select = 2 throughout.
  - rsp_data = 32'h005A0000, latency 7.
- Back-pressure: hold rsp_ready = 0 for 10 cycles with cmd_valid = 1:
  - rsp_valid and rsp_data stay stable.
  - cmd_ready = 0 until the cycle after rsp_ready.
- Assert rst during the WL phase of byte 1 of a write:
  - All controls are 0 within the same cycle, cmd_ready = 1.
  - A following read completes normally.
- Reserved op 2'b11: no macro control toggles; rsp_err = 1, rsp_data = 0, latency 2.
